rejection_sampler_driver: RTL and testbench

- Sequential driver sitting directly upstream of a generated combinational constraint checker (packed candidate in, single `sat` bit out).
- Produces pseudo-random candidate vectors from parallel LFSR lanes and presents each one to the checker.
- Samples the verdict, keeps accepted candidates and streams them out through a small FIFO with valid/ready handshake.
- Counts tries and accepts, and stops on reaching the target sample count or the try budget.

---
 rtl/sampler_pkg.sv | 29 ++
 rtl/sample_fifo.sv | 47 ++++
 rtl/rejection_sampler_driver.sv | 168 ++++++++++++++++
 tb/tb_rejection_sampler_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared state encoding, LFSR constants and lane helpers
package sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        GEN,
        WAIT,
        EVAL,
        PUSH,
        DONE
    } state_t;

    localparam logic [63:0] LFSR_TAPS   = 64'hD800000000000000;
    localparam logic [63:0] SEED_SPREAD = 64'h9E3779B97F4A7C15;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
    function automatic logic [63:0] lane_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // All-zero is the LFSR lock-up state, so it is never loaded
    function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int unsigned idx);
        logic [63:0] v;
        v = seed ^ (64'(idx) * SEED_SPREAD);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word-fall-through buffer for accepted samples
module sample_fifo #(
    parameter int VEC_W      = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [VEC_W-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [VEC_W-1:0] o_data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [VEC_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !w_empty;
    assign o_valid   = !w_empty;
    // Head is masked when empty so stale entries never appear after reset
    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/rejection_sampler_driver.sv
// rtl/rejection_sampler_driver.sv - LFSR candidate generator feeding a constraint checker
module rejection_sampler_driver
    import sampler_pkg::*;
#(
    parameter int VEC_W      = 512,
    parameter int CHECK_LAT  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [15:0]      n_samples,
    input  logic [31:0]      max_tries,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [VEC_W-1:0] smp_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      try_cnt,
    output logic [15:0]      accept_cnt
);

    localparam int LANES = VEC_W / 64;

    state_t           r_state;
    logic [63:0]      r_lane [LANES];
    logic [VEC_W-1:0] r_cand;
    logic [63:0]      r_seed;
    logic [15:0]      r_n_samples;
    logic [31:0]      r_max_tries;
    logic [31:0]      r_try_cnt;
    logic [15:0]      r_accept_cnt;
    logic [2:0]       r_wait_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic [63:0]      w_lane_seed [LANES];
    logic [63:0]      w_lane_next [LANES];
    logic [VEC_W-1:0] w_cand_next;
    logic [31:0]      w_try_next;
    logic [15:0]      w_acc_next;
    logic             w_fifo_full;
    logic             w_push;
    logic             w_budget_eval;
    logic             w_budget_now;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_seed[g]           = lane_seed(r_seed, g);
        assign w_lane_next[g]           = lane_step(r_lane[g]);
        assign w_cand_next[g*64 +: 64]  = w_lane_next[g];
    end

    assign w_try_next    = r_try_cnt + 32'd1;
    assign w_acc_next    = r_accept_cnt + 16'd1;
    assign w_budget_eval = (r_max_tries != 32'd0) && (w_try_next == r_max_tries);
    assign w_budget_now  = (r_max_tries != 32'd0) && (r_try_cnt == r_max_tries);
    assign w_push        = (r_state == PUSH) && !w_fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
            r_cand       <= '0;
            r_seed       <= '0;
            r_n_samples  <= '0;
            r_max_tries  <= '0;
            r_try_cnt    <= '0;
            r_accept_cnt <= '0;
            r_wait_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == DONE) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                    if (start) begin
                        r_seed       <= seed;
                        r_n_samples  <= n_samples;
                        r_max_tries  <= max_tries;
                        r_try_cnt    <= '0;
                        r_accept_cnt <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_state      <= (n_samples == 16'd0) ? DONE : SEED;
                    end
                end
                SEED: begin
                    for (int i = 0; i < LANES; i++) r_lane[i] <= w_lane_seed[i];
                    r_state <= GEN;
                end
                GEN: begin
                    for (int i = 0; i < LANES; i++) r_lane[i] <= w_lane_next[i];
                    r_cand     <= w_cand_next;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == 3'(CHECK_LAT - 1)) r_state <= EVAL;
                    else                                 r_wait_cnt <= r_wait_cnt + 3'd1;
                end
                EVAL: begin
                    r_try_cnt <= w_try_next;
                    if (sat_i) begin
                        r_state <= PUSH;
                    end else if (w_budget_eval) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_state <= GEN;
                    end
                end
                PUSH: begin
                    // Hold candidate and counters until the buffer has room
                    if (!w_fifo_full) begin
                        r_accept_cnt <= w_acc_next;
                        if (w_acc_next == r_n_samples) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_budget_now) begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= GEN;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sample_fifo #(
        .VEC_W      (VEC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_cand),
        .o_full      (w_fifo_full),
        .i_pop       (smp_ready),
        .o_valid     (smp_valid),
        .o_data      (smp_data)
    );

    assign cand_o     = r_cand;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign try_cnt    = r_try_cnt;
    assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_rejection_sampler_driver.sv
// tb/tb_rejection_sampler_driver.sv - self-checking bench for rejection_sampler_driver
module tb_rejection_sampler_driver;

    localparam int VEC_W = 512;
    localparam int LANES = VEC_W / 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [63:0]      seed;
    logic [15:0]      n_samples;
    logic [31:0]      max_tries;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic             smp_valid;
    logic             smp_ready;
    logic [VEC_W-1:0] smp_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [31:0]      try_cnt;
    logic [15:0]      accept_cnt;

    logic [1:0] sat_mode;
    logic [7:0] sat_thr;
    bit         rdy_rand;

    always #5 clk = ~clk;

    assign sat_i = (sat_mode == 2'd0) ? 1'b0 : (sat_mode == 2'd1) ? 1'b1 : (cand_o[7:0] < sat_thr);

    rejection_sampler_driver #(.VEC_W(VEC_W), .CHECK_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .n_samples(n_samples),
        .max_tries(max_tries), .cand_o(cand_o), .sat_i(sat_i), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .smp_data(smp_data), .busy(busy), .done(done),
        .timeout(timeout), .try_cnt(try_cnt), .accept_cnt(accept_cnt)
    );

    // Observed traffic, written only by the monitor
    logic [VEC_W-1:0] got_q [$];
    logic [VEC_W-1:0] cand_q [$];
    logic [VEC_W-1:0] last_cand = '0;
    logic [VEC_W-1:0] prev_data = '0;
    bit               prev_hold = 1'b0;
    int               stall_err = 0;
    int               valid_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (smp_valid) valid_cnt++;
            if (prev_hold && (!smp_valid || smp_data != prev_data)) stall_err++;
            prev_hold = smp_valid && !smp_ready;
            prev_data = smp_data;
            if (smp_valid && smp_ready) got_q.push_back(smp_data);
            if (cand_o != last_cand) begin
                cand_q.push_back(cand_o);
                last_cand = cand_o;
            end
        end else begin
            prev_hold = 1'b0;
            last_cand = '0;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) smp_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model: plain polynomial arithmetic over the spec's run rules
    logic [VEC_W-1:0] exp_q [$];
    logic [VEC_W-1:0] exp_c [$];
    logic [31:0]      exp_tries;
    int               exp_acc;
    bit               exp_to;

    function automatic bit sat_model(input logic [VEC_W-1:0] c, input logic [1:0] m, input logic [7:0] t);
        if (m == 2'd0) return 1'b0;
        if (m == 2'd1) return 1'b1;
        return c[7:0] < t;
    endfunction

    function automatic logic [63:0] galois(input logic [63:0] s);
        logic [63:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 64'hD800000000000000;
        return r;
    endfunction

    task automatic model_run(input logic [63:0] sd, input int n, input logic [31:0] mx,
                             input logic [1:0] m, input logic [7:0] t);
        logic [63:0]      ln [LANES];
        logic [VEC_W-1:0] c;
        exp_q.delete();
        exp_c.delete();
        exp_tries = 0;
        exp_acc   = 0;
        exp_to    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            ln[i] = sd ^ (64'(i) * 64'h9E3779B97F4A7C15);
            if (ln[i] == 64'd0) ln[i] = 64'd1;
        end
        if (n == 0) return;
        for (int it = 0; it < 100000; it++) begin
            for (int i = 0; i < LANES; i++) begin
                ln[i] = galois(ln[i]);
                c[i*64 +: 64] = ln[i];
            end
            exp_c.push_back(c);
            exp_tries++;
            if (sat_model(c, m, t)) begin
                exp_q.push_back(c);
                exp_acc++;
                if (exp_acc == n) break;
            end
            if (mx != 0 && exp_tries == mx) begin
                exp_to = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done_drain(input string tag);
        int c;
        c = 0;
        while (!done && c < 20000) begin tick(); c++; end
        check({tag, " done"}, VEC_W'(done), VEC_W'(1));
        c = 0;
        while (smp_valid && c < 20000) begin tick(); c++; end
        check({tag, " drained"}, VEC_W'(smp_valid), VEC_W'(0));
    endtask

    task automatic run(input logic [63:0] sd, input int n, input logic [31:0] mx, input logic [1:0] m,
                       input logic [7:0] t, input bit rr, input string tag, output int cbase);
        int gbase;
        sat_mode = m;
        sat_thr  = t;
        rdy_rand = rr;
        if (!rr) smp_ready = 1'b1;
        model_run(sd, n, mx, m, t);
        gbase     = got_q.size();
        cbase     = cand_q.size();
        seed      = sd;
        n_samples = 16'(n);
        max_tries = mx;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done_drain(tag);
        check({tag, " try_cnt"},    VEC_W'(try_cnt),    VEC_W'(exp_tries));
        check({tag, " accept_cnt"}, VEC_W'(accept_cnt), VEC_W'(exp_acc));
        check({tag, " timeout"},    VEC_W'(timeout),    VEC_W'(exp_to));
        check({tag, " busy"},       VEC_W'(busy),       VEC_W'(0));
        check({tag, " n_out"},      VEC_W'(got_q.size() - gbase), VEC_W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++)
            check($sformatf("%s sample%0d", tag, i), got_q[gbase + i], exp_q[i]);
    endtask

    typedef struct {
        logic [63:0] sd;
        int          n;
        logic [31:0] mx;
        logic [1:0]  m;
        logic [31:0] e_try;
        logic [15:0] e_acc;
        bit          e_to;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cb, cb1, cb2, vbase, zero_lanes;
        logic [63:0] sd;

        tbl[0] = '{64'h1234, 0, 32'd0,  2'd1, 32'd0,  16'd0, 1'b0};
        tbl[1] = '{64'hA5A5, 3, 32'd0,  2'd1, 32'd3,  16'd3, 1'b0};
        tbl[2] = '{64'h77,   5, 32'd10, 2'd0, 32'd10, 16'd0, 1'b1};
        tbl[3] = '{64'h99,   5, 32'd3,  2'd1, 32'd3,  16'd3, 1'b1};
        tbl[4] = '{64'h5,    1, 32'd1,  2'd1, 32'd1,  16'd1, 1'b0};

        rst_n = 1'b0; start = 1'b0; seed = '0; n_samples = '0; max_tries = '0;
        smp_ready = 1'b1; sat_mode = 2'd0; sat_thr = 8'd0; rdy_rand = 1'b0;
        tick(); tick();
        check("rst busy",  VEC_W'(busy),  VEC_W'(0));
        check("rst done",  VEC_W'(done),  VEC_W'(0));
        check("rst valid", VEC_W'(smp_valid), VEC_W'(0));
        check("rst cand",  cand_o, '0);
        check("rst try",   VEC_W'(try_cnt), VEC_W'(0));
        rst_n = 1'b1;
        tick();

        // Zero-sample run: done two cycles after start, no samples
        vbase = valid_cnt;
        seed = 64'h42; n_samples = 16'd0; max_tries = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("n0 done early", VEC_W'(done), VEC_W'(0));
        tick();
        check("n0 done",    VEC_W'(done),    VEC_W'(1));
        check("n0 timeout", VEC_W'(timeout), VEC_W'(0));
        check("n0 try",     VEC_W'(try_cnt), VEC_W'(0));
        check("n0 busy",    VEC_W'(busy),    VEC_W'(0));
        tick(); tick();
        check("n0 no valid", VEC_W'(valid_cnt - vbase), VEC_W'(0));

        for (int k = 0; k < 5; k++) begin
            run(tbl[k].sd, tbl[k].n, tbl[k].mx, tbl[k].m, 8'd0, 1'b0, $sformatf("tbl%0d", k), cb);
            check($sformatf("tbl%0d fixed try", k), VEC_W'(try_cnt),    VEC_W'(tbl[k].e_try));
            check($sformatf("tbl%0d fixed acc", k), VEC_W'(accept_cnt), VEC_W'(tbl[k].e_acc));
            check($sformatf("tbl%0d fixed to", k),  VEC_W'(timeout),    VEC_W'(tbl[k].e_to));
        end

        // Zero seed: lane 0 forced to 1, no lane ever all-zero
        run(64'd0, 1, 32'd100, 2'd0, 8'd0, 1'b0, "seed0", cb);
        check("seed0 lane0 first", VEC_W'(cand_q[cb][63:0]), VEC_W'(64'hD800000000000000));
        zero_lanes = 0;
        for (int i = cb; i < cand_q.size(); i++)
            for (int l = 0; l < LANES; l++)
                if (cand_q[i][l*64 +: 64] == 64'd0) zero_lanes++;
        check("seed0 zero lanes", VEC_W'(zero_lanes), VEC_W'(0));
        check("seed0 ncand", VEC_W'(cand_q.size() - cb), VEC_W'(100));

        // Back-pressure: FIFO fills, FSM stalls in PUSH, then drains in order
        sat_mode = 2'd1; rdy_rand = 1'b0; smp_ready = 1'b0;
        model_run(64'hBEEF, 6, 32'd0, 2'd1, 8'd0);
        cb1 = got_q.size();
        seed = 64'hBEEF; n_samples = 16'd6; max_tries = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("bp try",   VEC_W'(try_cnt),    VEC_W'(5));
        check("bp acc",   VEC_W'(accept_cnt), VEC_W'(4));
        check("bp busy",  VEC_W'(busy),       VEC_W'(1));
        check("bp head",  smp_data, exp_q[0]);
        smp_ready = 1'b1;
        wait_done_drain("bp");
        check("bp n_out", VEC_W'(got_q.size() - cb1), VEC_W'(6));
        for (int i = 0; i < 6 && cb1 + i < got_q.size(); i++)
            check($sformatf("bp sample%0d", i), got_q[cb1 + i], exp_q[i]);

        // Reset in WAIT with two samples queued, then identical replay
        smp_ready = 1'b0;
        cb1 = cand_q.size();
        seed = 64'hC0FFEE; n_samples = 16'd10; max_tries = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && accept_cnt != 16'd2; i++) tick();
        check("rw acc2", VEC_W'(accept_cnt), VEC_W'(2));
        tick();
        rst_n = 1'b0;
        #1;
        check("rw busy",  VEC_W'(busy),       VEC_W'(0));
        check("rw done",  VEC_W'(done),       VEC_W'(0));
        check("rw to",    VEC_W'(timeout),    VEC_W'(0));
        check("rw try",   VEC_W'(try_cnt),    VEC_W'(0));
        check("rw acc",   VEC_W'(accept_cnt), VEC_W'(0));
        check("rw cand",  cand_o, '0);
        check("rw valid", VEC_W'(smp_valid),  VEC_W'(0));
        check("rw data",  smp_data, '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run(64'hC0FFEE, 3, 32'd0, 2'd1, 8'd0, 1'b0, "replay", cb2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("replay c%0d old", i), cand_q[cb1 + i], exp_c[i]);
            check($sformatf("replay c%0d new", i), cand_q[cb2 + i], exp_c[i]);
        end

        // Randomized runs against the model with random consumer stalls
        for (int k = 0; k < 8; k++) begin
            sd = {$urandom, $urandom};
            run(sd, $urandom_range(1, 5), (k % 2 == 1) ? 32'($urandom_range(1, 40)) : 32'd0,
                2'd2, 8'($urandom_range(20, 255)), 1'b1, $sformatf("rnd%0d", k), cb);
        end
        rdy_rand = 1'b0;
        smp_ready = 1'b1;

        check("stall stable", VEC_W'(stall_err), VEC_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
